// File: rtl/q_sys_freq_pkg.sv
// q_sys_freq_pkg: shared widths and gate constants for the q_sys frequency meter
package q_sys_freq_pkg;
   localparam int          FREQ_CNT_W = 16;
   localparam int unsigned GATE_1S    = 50_000_000;
   function automatic int gate_width(input int unsigned cycles);
      return $clog2(cycles);
   endfunction
endpackage

// File: rtl/q_sys_sync_edge.sv
// q_sys_sync_edge: SYNC_STAGES-deep synchronizer followed by a rising-edge detector
module q_sys_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sig,
   output logic rise
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/q_sys_freq_meter.sv
// q_sys_freq_meter: counts sig_in rising edges per GATE_CYCLES window and holds the result for the PIO
// Define FREQ_METER_SAT_EN to saturate the count and flag the overflow on freq_ovf.
module q_sys_freq_meter
   import q_sys_freq_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = GATE_1S,
   parameter int          CNT_W       = FREQ_CNT_W,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq_out,
   output logic             freq_upd,
   output logic             freq_ovf
);
   localparam int                GATE_W    = gate_width(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   logic              rise, terminal, ovf_next;
   logic [GATE_W-1:0] gate_cnt;
   logic [CNT_W-1:0]  edge_cnt, edge_next;
   q_sys_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .sig    (sig_in),
      .rise   (rise)
   );
   assign terminal = en && (gate_cnt == '0);
`ifdef FREQ_METER_SAT_EN
   logic window_ovf;
   always_comb begin
      edge_next = &edge_cnt ? edge_cnt : edge_cnt + CNT_W'(rise);
      ovf_next  = window_ovf | (&edge_cnt & rise);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) window_ovf <= 1'b0;
      else window_ovf <= en && !terminal && ovf_next;
`else
   assign edge_next = edge_cnt + CNT_W'(rise);
   assign ovf_next  = 1'b0;
`endif
   // the terminal cycle's own rise is folded into the closing window via edge_next
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         gate_cnt <= GATE_LAST;
         edge_cnt <= '0;
         freq_out <= '0;
         freq_upd <= 1'b0;
         freq_ovf <= 1'b0;
      end else begin
         freq_upd <= terminal;
         if (!en || terminal) begin
            gate_cnt <= GATE_LAST;
            edge_cnt <= '0;
         end else begin
            gate_cnt <= gate_cnt - GATE_W'(1);
            edge_cnt <= edge_next;
         end
         if (terminal) begin
            freq_out <= edge_next;
            freq_ovf <= ovf_next;
         end
      end
endmodule

// File: tb/tb_q_sys_freq_meter.sv
// tb_q_sys_freq_meter: randomized and directed checks against a window-count reference model
module tb_q_sys_freq_meter;
   localparam int G = 100;
`ifdef FREQ_METER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   logic        clk = 1'b0, reset_n = 1'b0, en = 1'b0, sig_in = 1'b0;
   logic [15:0] freq_out;
   logic        freq_upd, freq_ovf;
   logic [3:0]  freq_out4;
   logic        freq_upd4, freq_ovf4;
   int          n_chk = 0, n_fail = 0;
   int          per = 0, gen = 0;
   int          phase = 0, cnt = 0, m_last = 0, m_upd = 0;
   bit          sq[$] = '{0, 0, 0, 0};
   q_sys_freq_meter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .sig_in(sig_in),
      .freq_out(freq_out), .freq_upd(freq_upd), .freq_ovf(freq_ovf)
   );
   q_sys_freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .reset_n(reset_n), .en(en), .sig_in(sig_in),
      .freq_out(freq_out4), .freq_upd(freq_upd4), .freq_ovf(freq_ovf4)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic step();
      int r;
      if (per > 0) begin
         sig_in = (gen % per) < (per / 2);
         gen++;
      end
      @(posedge clk);
      if (!reset_n) begin
         sq = '{0, 0, 0, 0};
         phase = 0;
         cnt = 0;
         m_last = 0;
         m_upd = 0;
      end else begin
         sq.push_front(sig_in);
         void'(sq.pop_back());
         r = (sq[2] && !sq[3]) ? 1 : 0;
         if (!en) begin
            phase = 0;
            cnt = 0;
            m_upd = 0;
         end else if (phase == G - 1) begin
            m_last = cnt + r;
            m_upd = 1;
            phase = 0;
            cnt = 0;
         end else begin
            cnt += r;
            phase++;
            m_upd = 0;
         end
      end
      @(negedge clk);
      check("upd", freq_upd, m_upd);
      check("out", freq_out, m_last % 65536);
      check("ovf", freq_ovf, (SAT && m_last > 65535) ? 1 : 0);
      check("upd4", freq_upd4, m_upd);
      check("out4", freq_out4, SAT ? (m_last > 15 ? 15 : m_last) : m_last % 16);
      check("ovf4", freq_ovf4, (SAT && m_last > 15) ? 1 : 0);
   endtask
   task automatic wait_upd(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!freq_upd && n < 300);
      check("upd_wait", freq_upd, 1);
   endtask
   initial begin
      int n, nu;
      per = 2;
      en = 1'b1;
      repeat (10) step();
      check("rst_out", freq_out, 0);
      check("rst_upd", freq_upd, 0);
      check("rst_ovf", freq_ovf, 0);
      per = 10;
      reset_n = 1'b1;
      wait_upd(n);
      check("first_upd_lat", n, G);
      for (int i = 0; i < 3; i++) begin
         wait_upd(n);
         check("win_len", n, G);
         check("win_val", freq_out, 10);
      end
      per = 0;
      sig_in = 1'b0;
      repeat (5) step();
      wait_upd(n);
      for (int i = 0; i < G; i++) begin
         sig_in = (i == 10 || i == 30 || i == 50 || i == 97);
         step();
      end
      check("term_upd", freq_upd, 1);
      check("term_val", freq_out, 4);
      sig_in = 1'b0;
      wait_upd(n);
      check("next_val", freq_out, 0);
      per = 10;
      wait_upd(n);
      wait_upd(n);
      check("pre_hold_val", freq_out, 10);
      repeat (50) step();
      en = 1'b0;
      nu = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (freq_upd) nu++;
      end
      check("hold_noupd", nu, 0);
      check("hold_val", freq_out, 10);
      en = 1'b1;
      wait_upd(n);
      check("reen_lat", n, G);
      check("reen_val", freq_out, 10);
      per = 4;
      wait_upd(n);
      wait_upd(n);
      check("p4_val16", freq_out, 25);
      check("p4_val4", freq_out4, SAT ? 15 : 9);
      check("p4_ovf4", freq_ovf4, SAT ? 1 : 0);
      per = 10;
      wait_upd(n);
      wait_upd(n);
      repeat (60) step();
      reset_n = 1'b0;
      repeat (3) step();
      check("mid_rst_out", freq_out, 0);
      check("mid_rst_ovf4", freq_ovf4, 0);
      reset_n = 1'b1;
      wait_upd(n);
      check("post_rst_lat", n, G);
      check("post_rst_val", freq_out, m_last);
      for (int k = 0; k < 10; k++) begin
         per = $urandom_range(2, 20);
         for (int i = 0, len = $urandom_range(80, 300); i < len; i++) begin
            if ($urandom_range(0, 99) < 2) en = ~en;
            if ($urandom_range(0, 999) < 3) reset_n = 1'b0;
            else reset_n = 1'b1;
            step();
         end
      end
      en = 1'b1;
      reset_n = 1'b1;
      per = 6;
      wait_upd(n);
      wait_upd(n);
      check("final_len", n, G);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
